// File: rtl/svn_pkg.sv
// svn_pkg: shared constants and helpers for the scan multiplexer.
//   SVN_MAX_DIGITS : widest supported display (anode vectors are sized to it)
//   SVN_IDX_W      : digit index width at SVN_MAX_DIGITS
//   SVN_AN_OFF     : anode pattern with every digit dark
//   an_onehot_n()  : active-low anode pattern selecting one digit
package svn_pkg;

    localparam int SVN_MAX_DIGITS = 8;
    localparam int SVN_IDX_W      = $clog2(SVN_MAX_DIGITS);

    localparam logic [SVN_MAX_DIGITS-1:0] SVN_AN_OFF = '1;

    function automatic logic [SVN_MAX_DIGITS-1:0] an_onehot_n(input logic [SVN_IDX_W-1:0] index);
        return ~(SVN_MAX_DIGITS'(1) << index);
    endfunction

endpackage

// File: rtl/svn_refresh_prescaler.sv
// svn_refresh_prescaler: dwell counter for the digit scan.
// Counts 0..REFRESH_DIV-1 and wraps; tick is high on the wrap cycle, so the
// edge that ends that cycle is the one on which the scan index advances.
//   clk     : system clock
//   sys_rst : asynchronous, active-high reset
//   tick    : high during the last cycle of each dwell period
module svn_refresh_prescaler #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic sys_rst,
    output logic tick
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] dwell;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            dwell <= '0;
        end else if (dwell == DWELL_LAST) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    assign tick = (dwell == DWELL_LAST);

endmodule

// File: rtl/svn_scan_mux.sv
// svn_scan_mux: multi-digit scan multiplexer feeding a seven-segment decoder.
// A loaded value is parked in a pending buffer and committed to the active
// buffer only at a frame boundary, so a frame never mixes two values.
//   clk            : system clock
//   sys_rst        : asynchronous, active-high reset
//   value          : display value, nibble i is digit i
//   load           : single-cycle strobe capturing value
//   digit          : nibble for the decoder input
//   blank          : current digit suppressed
//   AN             : active-low anode enables, at most one bit low
//   frame_tick     : one-cycle pulse on the first cycle of digit 0
//   update_pending : a loaded value awaits commit
// Optional feature: define SVN_LEADING_ZERO_BLANK_EN to blank digits above the
// most significant nonzero nibble (digit 0 always shown).
module svn_scan_mux
    import svn_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    output logic [3:0]            digit,
    output logic                  blank,
    output logic [DIGITS-1:0]     AN,
    output logic                  frame_tick,
    output logic                  update_pending
);

    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [SVN_MAX_DIGITS-1:0] AN_RESET_FULL = an_onehot_n('0);
    localparam logic [DIGITS-1:0] AN_RESET = AN_RESET_FULL[DIGITS-1:0];
    localparam logic [DIGITS-1:0] AN_OFF   = SVN_AN_OFF[DIGITS-1:0];

    logic                      tick;
    logic                      boundary;
    logic [IW-1:0]             idx;
    logic [IW-1:0]             idx_nx;
    logic [4*DIGITS-1:0]       active;
    logic [4*DIGITS-1:0]       active_nx;
    logic [4*DIGITS-1:0]       pending;
    logic                      pend_valid;
    logic                      pend_valid_nx;
    logic [3:0]                digit_sel;
    logic [3:0]                digit_nx;
    logic                      blank_nx;
    logic [SVN_MAX_DIGITS-1:0] an_full;
    logic [DIGITS-1:0]         an_nx;

    svn_refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk     (clk),
        .sys_rst (sys_rst),
        .tick    (tick)
    );

    always_comb begin
        idx_nx   = idx;
        boundary = 1'b0;
        if (tick) begin
            if (idx == LAST_IDX) begin
                idx_nx   = '0;
                boundary = 1'b1;
            end else begin
                idx_nx = idx + 1'b1;
            end
        end
    end

    // A load coinciding with the boundary bypasses the pending buffer so it is
    // visible on the very next cycle.
    always_comb begin
        active_nx     = active;
        pend_valid_nx = pend_valid;
        if (boundary && load) begin
            active_nx     = value;
            pend_valid_nx = 1'b0;
        end else if (boundary && pend_valid) begin
            active_nx     = pending;
            pend_valid_nx = 1'b0;
        end else if (load) begin
            pend_valid_nx = 1'b1;
        end
    end

    // Outputs are computed from next-state index and active value so that
    // digit, AN and blank all switch on the same edge as the index.
    assign digit_sel = active_nx[4*idx_nx +: 4];
    assign an_full   = an_onehot_n(SVN_IDX_W'(idx_nx));

`ifdef SVN_LEADING_ZERO_BLANK_EN
    logic [IW-1:0] msd;

    always_comb begin
        msd = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (active_nx[4*i +: 4] != 4'h0) begin
                msd = IW'(i);
            end
        end
    end

    assign blank_nx = (idx_nx > msd);
`else
    assign blank_nx = 1'b0;
`endif

    always_comb begin
        digit_nx = digit_sel;
        an_nx    = an_full[DIGITS-1:0];
        if (blank_nx) begin
            digit_nx = 4'h0;
            an_nx    = AN_OFF;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            idx        <= '0;
            active     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            digit      <= 4'h0;
            blank      <= 1'b0;
            AN         <= AN_RESET;
            frame_tick <= 1'b0;
        end else begin
            idx        <= idx_nx;
            active     <= active_nx;
            pend_valid <= pend_valid_nx;
            if (load) begin
                pending <= value;
            end
            digit      <= digit_nx;
            blank      <= blank_nx;
            AN         <= an_nx;
            frame_tick <= boundary;
        end
    end

    assign update_pending = pend_valid;

endmodule
